apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter: ADDR_W, 32, PADDR/cmd_addr width.
REQ-002 Parameter: DATA_W, 32, data width; multiple of 8.
REQ-003 Parameter: TIMEOUT, 16, max ACCESS cycles before forced error; 0 disables the timeout.
REQ-004 PCLK  in  1  clock; all state changes on the rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  bridge can accept a command.
REQ-008 cmd_write  in  1  1=write, 0=read.
REQ-009 cmd_addr  in  ADDR_W  target address.
REQ-010 cmd_wdata  in  DATA_W  write data.
REQ-011 cmd_strb  in  DATA_W/8  write byte enables.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  transfer failed (PSLVERR or timeout).
REQ-016 rsp_timeout  out  1  failure caused by timeout.
REQ-017 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-018 PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8.
REQ-019 PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1.

Function
REQ-020 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP; any other encoding SHALL go to IDLE on the next edge.
REQ-021 cmd_ready SHALL be 1 only in IDLE with PRESETn high; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-022 On accept: PADDR, PWRITE and PWDATA SHALL load from cmd_*; PSTRB SHALL load cmd_strb for writes and 0 for reads; state SHALL go to SETUP.
REQ-023 In SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then state SHALL go to ACCESS.
REQ-024 In ACCESS: PSEL=1, PENABLE=1 until completion.
REQ-025 PADDR, PWRITE, PWDATA and PSTRB SHALL hold constant from SETUP through completion, and SHALL retain their values until the next accept.
REQ-026 Completion SHALL occur on an ACCESS-cycle edge with PREADY=1. At that edge: rsp_rdata=PRDATA for reads (0 for writes), rsp_err=PSLVERR, rsp_timeout=0, and state SHALL go to RESP.
REQ-027 PREADY, PRDATA and PSLVERR SHALL be ignored outside ACCESS; PSLVERR SHALL be ignored when PREADY=0.
REQ-028 The wait counter SHALL clear on entry to SETUP and increment on each ACCESS cycle with PREADY=0.
REQ-029 If TIMEOUT>0 and the counter equals TIMEOUT-1 in an ACCESS cycle with PREADY=0, the transfer SHALL complete with rsp_err=1, rsp_timeout=1, rsp_rdata=0; ACCESS therefore lasts at most TIMEOUT cycles.
REQ-030 If PREADY=1 arrives in the same cycle the timeout fires, PREADY SHALL win (normal completion).
REQ-031 In RESP: PSEL=0, PENABLE=0, rsp_valid=1, with rsp_* held stable until an edge with rsp_ready=1; state then SHALL go to IDLE.
REQ-032 rsp_valid SHALL be 0 in all states except RESP.
REQ-033 Minimum latency: accept at edge T, SETUP in cycle T+1, ACCESS in cycle T+2 with PREADY=1, rsp_valid=1 in cycle T+3.
REQ-034 Only one transfer SHALL be outstanding; the next accept is no earlier than the cycle after the RESP handshake.
REQ-035 PSEL and PENABLE SHALL be driven from registered state only (glitch-free).

Reset
REQ-036 While PRESETn=0: state=IDLE, counter=0, and PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and cmd_ready SHALL all be 0.
REQ-037 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately (asynchronously), and the aborted transfer SHALL produce no response.
REQ-038 cmd_ready SHALL be 1 in the first cycle after PRESETn deasserts.

Verification
REQ-039 Read: cmd addr=0x4, slave PREADY=1 in first ACCESS cycle, PRDATA=0xDEADBEEF -> one SETUP, one ACCESS cycle; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at T+3.
REQ-040 Write with wait states: addr=0x8, wdata=0x12345678, strb=0xF, PREADY low for 3 ACCESS cycles -> PADDR/PWDATA/PSTRB stable for 4 ACCESS cycles; rsp_rdata=0, rsp_err=0.
REQ-041 Slave error: addr=0x40, PREADY=1 with PSLVERR=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-042 Timeout: TIMEOUT=16, PREADY held 0 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1. Also: PREADY=1 on the 16th cycle -> normal completion.
REQ-043 Backpressure: rsp_ready low for 5 cycles with cmd_valid held high -> rsp_* stable, cmd_ready=0 throughout; accept occurs one cycle after the rsp handshake.
REQ-044 Reset in ACCESS -> PSEL=0 immediately, no rsp_valid; after release, cmd_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-outstanding command/response to APB master bridge with a
//            bounded ACCESS phase. A slave that stalls for too long is
//            completed with an error flagged as a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  // command side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  // response side
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  // APB master
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q,       state_d;
  logic [CNT_W-1:0]    cnt_q,         cnt_d;
  logic                psel_q,        psel_d;
  logic                penable_q,     penable_d;
  logic                rsp_valid_q,   rsp_valid_d;
  logic                pwrite_q,      pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,       paddr_d;
  logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
  logic [STRB_W-1:0]   pstrb_q,       pstrb_d;
  logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                rsp_err_q,     rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  // Next-state, address/data capture, wait counting and response capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY takes priority over a timeout firing in the same cycle.
        if (PREADY) begin
          rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Control outputs are precomputed from the next state so they leave flops.
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // cmd_ready is gated by PRESETn so it is low for the whole reset window.
  assign cmd_ready   = PRESETn && (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Scoreboard bench for apb_master_bridge; the bench plays the APB
//            slave and the command/response client.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;

  apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transfer. Called at a negedge with the bridge idle.
  // wait_n >= TIMEOUT means the slave never answers.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int wait_n, input logic slverr,
                      input logic [31:0] rdata, input int rsp_hold, input logic hold_valid);
    rsp_t        e;
    int          acc;
    int          cyc;
    int          exp_acc;
    bit          is_to;
    logic [3:0]  xstrb;
    is_to   = (wait_n >= TIMEOUT);
    xstrb   = wr ? strb : 4'h0;
    e.rdata = (wr || slverr || is_to) ? 32'h0 : rdata;
    e.err   = slverr || is_to;
    e.to    = is_to;
    exp_acc = is_to ? TIMEOUT : wait_n + 1;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    sb_q.push_back(e);

    @(negedge PCLK);
    cyc = 1;
    cmd_valid = 1'b0;
    check("setup_ctrl", {PSEL, PENABLE}, 2'b10);
    check("setup_bus", {PADDR, PWDATA, PSTRB, PWRITE}, {addr, wdata, xstrb, wr});
    // Slave signals outside ACCESS must have no effect.
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = 32'hBAD0_BAD0;

    acc = 0;
    while (acc < 64) begin
      @(negedge PCLK);
      cyc++;
      if (!(PSEL && PENABLE)) break;
      acc++;
      check("access_bus", {PADDR, PWDATA, PSTRB, PWRITE}, {addr, wdata, xstrb, wr});
      if (acc > wait_n) begin
        PREADY  = 1'b1;
        PSLVERR = slverr;
        PRDATA  = rdata;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b1;   // must be ignored while PREADY is low
        PRDATA  = ~rdata;
      end
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    check("access_cycles", acc, exp_acc);
    check("rsp_latency", cyc, exp_acc + 2);
    check("resp_ctrl", {PSEL, PENABLE, rsp_valid}, 3'b001);

    cmd_valid = hold_valid;
    for (int i = 0; i < rsp_hold; i++) begin
      rsp_ready = 1'b0;
      check("bp_rsp_stable", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, sb_q[0]});
      check("bp_cmd_ready", cmd_ready, 1'b0);
      @(negedge PCLK);
    end
    rsp_ready = 1'b1;
    if (rsp_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", rsp_err, e.err);
      check("rsp_timeout", rsp_timeout, e.to);
    end else begin
      check("rsp_valid_hs", rsp_valid, 1'b1);
    end
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 1'b0);
    check("cmd_ready_after", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b1;          // must not be accepted during reset
    cmd_write = 1'b1;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'hFFFF_FFFF;
    cmd_strb  = 4'hF;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = 32'h0;
    repeat (3) @(negedge PCLK);
    check("reset_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 7'b0);
    check("reset_bus", {PADDR, PWDATA, PSTRB, rsp_rdata}, 100'h0);
    cmd_valid = 1'b0;
    PRESETn   = 1'b1;
    #1;
    check("cmd_ready_release", cmd_ready, 1'b1);
    @(negedge PCLK);

    // zero-wait read
    xfer(1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    // write with three wait states
    xfer(1'b1, 32'h8, 32'h1234_5678, 4'hF, 3, 1'b0, 32'h5555_AAAA, 0, 1'b0);
    // slave error on a read
    xfer(1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b1, 32'h1122_3344, 0, 1'b0);
    // slave never answers
    xfer(1'b0, 32'h20, 32'h0, 4'h0, TIMEOUT, 1'b0, 32'h0, 0, 1'b0);
    // PREADY on the last allowed ACCESS cycle
    xfer(1'b0, 32'h24, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    // response backpressure with the next command already waiting
    xfer(1'b1, 32'h2C, 32'hA5A5_0F0F, 4'h5, 1, 1'b0, 32'h0, 5, 1'b1);
    xfer(1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_F00D, 0, 1'b0);

    // reset in the middle of ACCESS
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h10;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("rst_pre_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("rst_async_ctrl", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0);
    check("rst_async_addr", PADDR, 32'h0);
    repeat (2) begin
      @(negedge PCLK);
      check("rst_no_rsp", rsp_valid, 1'b0);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_release_ready", {cmd_ready, rsp_valid, PSEL}, 3'b100);
    xfer(1'b0, 32'h14, 32'h0, 4'hF, 0, 1'b0, 32'h7777_1234, 0, 1'b0);

    // a few randomised transfers
    for (int k = 0; k < 4; k++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 2), 1'b0);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
